yuv_channel_tx: RTL and testbench

- Camera-side producer for the three DMA YUV input channels (Y, U, V).
- Takes a YUYV 4:2:2 pixel stream from the camera capture logic and demultiplexes it into separate 8-bit Y, U and V channel streams.
- Each channel is buffered in its own FIFO and presented on the z/vz/lz channel handshake that the DMA YUV reader consumes.
- Also generates the DMA/FIFO clear pulse and a sticky overflow status bit for the HPS control PIOs.

---
 rtl/yuv_tx_pkg.sv | 10 +
 rtl/yuv_tx_fifo.sv | 61 ++++++
 rtl/yuv_channel_tx.sv | 163 ++++++++++++++++
 tb/tb_yuv_channel_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yuv_tx_pkg.sv
// Shared constants and state encodings for the YUV channel producer.
package yuv_tx_pkg;
  localparam int PIX_W    = 16;
  localparam int CH_W     = 8;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  typedef enum logic [1:0] {PH_EVEN, PH_ODD_ACC, PH_ODD_DROP} phase_e;
  typedef enum logic {ST_IDLE, ST_CLEAR} clr_st_e;
endpackage

// File: rtl/yuv_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head word while not empty.
module yuv_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] free_cnt
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, wr_en, rd_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign free_cnt = CW'(DEPTH) - count_q;
  // A push while full is only honoured alongside a pop (slot freed the same edge).
  assign wr_en    = push & (~full | pop) & ~flush;
  assign rd_en    = pop & ~empty & ~flush;
  assign dout     = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/yuv_channel_tx.sv
// YUYV 4:2:2 demux into Y/U/V FWFT channel FIFOs with clear pulse and overflow status.
// Define YUV_TX_DROP_CNT_EN to add the saturating drop_count output.
module yuv_channel_tx
  import yuv_tx_pkg::*;
#(
  parameter int Y_DEPTH      = 64,
  parameter int C_DEPTH      = 32,
  parameter int CLEAR_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [3:0]       ctrl,
  output logic             status_overflow,
  output logic             clear_dma_and_fifo,
  output logic [CH_W-1:0]  y_z,
  output logic             y_vz,
  input  logic             y_lz,
  output logic [CH_W-1:0]  u_z,
  output logic             u_vz,
  input  logic             u_lz,
  output logic [CH_W-1:0]  v_z,
  output logic             v_vz,
  input  logic             v_lz
`ifdef YUV_TX_DROP_CNT_EN
  ,output logic [15:0]     drop_count
`endif
);
  localparam int YCW = $clog2(Y_DEPTH) + 1;
  localparam int CCW = $clog2(C_DEPTH) + 1;
  localparam int KW  = $clog2(CLEAR_CYCLES + 1);

  clr_st_e         st_q, st_d;
  phase_e          ph_q, ph_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            clr_prev_q;
  logic            clearing, space, is_even;
  logic            y_push, u_push, v_push;
  logic            y_empty, u_empty, v_empty;
  logic [CH_W-1:0] y_dout, u_dout, v_dout;
  logic [YCW-1:0]  y_free;
  logic [CCW-1:0]  u_free, v_free;
  logic [1:0]      ctrl_unused;

  assign ctrl_unused = ctrl[3:2];
  assign clearing    = (st_q == ST_CLEAR);
  // Whole pair must fit: two Y slots and one of each chroma.
  assign space   = (y_free >= YCW'(2)) && (u_free != '0) && (v_free != '0);
  assign is_even = pix_sof || (ph_q == PH_EVEN);

`ifdef YUV_TX_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  assign drop_count = drop_q;
`endif

  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    y_push = 1'b0;
    u_push = 1'b0;
    v_push = 1'b0;
`ifdef YUV_TX_DROP_CNT_EN
    drop_d = drop_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (ctrl[CTRL_CLR] && !clr_prev_q) begin
          st_d  = ST_CLEAR;
          cnt_d = KW'(CLEAR_CYCLES - 1);
        end
        if (pix_valid) begin
          if (is_even) begin
            if (pix_sof && ph_q == PH_ODD_ACC) ovf_d = 1'b1;
            if (ctrl[CTRL_EN] && space) begin
              y_push = 1'b1;
              u_push = 1'b1;
              ph_d   = PH_ODD_ACC;
            end else begin
              ph_d = PH_ODD_DROP;
              if (ctrl[CTRL_EN]) begin
                ovf_d = 1'b1;
`ifdef YUV_TX_DROP_CNT_EN
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
`endif
              end
            end
          end else if (ph_q == PH_ODD_ACC) begin
            // Slots were reserved at the even pixel, so no space check here.
            y_push = 1'b1;
            v_push = 1'b1;
            ph_d   = PH_EVEN;
          end else begin
            ph_d = PH_EVEN;
          end
        end
      end
      ST_CLEAR: begin
        ovf_d = 1'b0;
        ph_d  = PH_EVEN;
`ifdef YUV_TX_DROP_CNT_EN
        drop_d = '0;
`endif
        if (cnt_q == '0) st_d = ST_IDLE;
        else             cnt_d = cnt_q - KW'(1);
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      ph_q       <= PH_EVEN;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      clr_prev_q <= ctrl[CTRL_CLR];
    end
  end

`ifdef YUV_TX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end
`endif

  assign status_overflow    = ovf_q;
  assign clear_dma_and_fifo = clearing;

  // Channels go quiet for the whole clear window, even before the flush lands.
  assign y_vz = ~y_empty & ~clearing;
  assign u_vz = ~u_empty & ~clearing;
  assign v_vz = ~v_empty & ~clearing;
  assign y_z  = clearing ? '0 : y_dout;
  assign u_z  = clearing ? '0 : u_dout;
  assign v_z  = clearing ? '0 : v_dout;

  yuv_tx_fifo #(.DEPTH(Y_DEPTH), .W(CH_W)) u_y_fifo (
    .clk(clk), .rst_n(rst_n), .push(y_push), .pop(y_lz & y_vz), .flush(clearing),
    .din(pix_data[7:0]), .dout(y_dout), .empty(y_empty), .free_cnt(y_free)
  );

  yuv_tx_fifo #(.DEPTH(C_DEPTH), .W(CH_W)) u_u_fifo (
    .clk(clk), .rst_n(rst_n), .push(u_push), .pop(u_lz & u_vz), .flush(clearing),
    .din(pix_data[15:8]), .dout(u_dout), .empty(u_empty), .free_cnt(u_free)
  );

  yuv_tx_fifo #(.DEPTH(C_DEPTH), .W(CH_W)) u_v_fifo (
    .clk(clk), .rst_n(rst_n), .push(v_push), .pop(v_lz & v_vz), .flush(clearing),
    .din(pix_data[15:8]), .dout(v_dout), .empty(v_empty), .free_cnt(v_free)
  );
endmodule

// File: tb/tb_yuv_channel_tx.sv
// Scoreboard bench for yuv_channel_tx: expected channel bytes are queued at stimulus time.
module tb_yuv_channel_tx;
  localparam int CLR_N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid, pix_sof;
  logic [15:0] pix_data;
  logic [3:0]  ctrl;
  logic        status_overflow, clear_dma_and_fifo;
  logic [7:0]  y_z, u_z, v_z;
  logic        y_vz, u_vz, v_vz;
  logic        y_lz, u_lz, v_lz;
`ifdef YUV_TX_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] yq[$], uq[$], vq[$];

  always #5 clk = ~clk;

  yuv_channel_tx #(.Y_DEPTH(4), .C_DEPTH(2), .CLEAR_CYCLES(CLR_N)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .ctrl(ctrl), .status_overflow(status_overflow),
    .clear_dma_and_fifo(clear_dma_and_fifo),
    .y_z(y_z), .y_vz(y_vz), .y_lz(y_lz),
    .u_z(u_z), .u_vz(u_vz), .u_lz(u_lz),
    .v_z(v_z), .v_vz(v_vz), .v_lz(v_lz)
`ifdef YUV_TX_DROP_CNT_EN
    ,.drop_count(drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [7:0] y, input logic [7:0] c, input bit sof);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = {c, y};
    step();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic lz_all(input logic l);
    y_lz = l; u_lz = l; v_lz = l;
  endtask

  task automatic chk_drained(input string tag);
    chk(tag, 32'(yq.size() + uq.size() + vq.size()), 0);
  endtask

  // Enter clear, re-toggle ctrl[1] mid-clear (must be ignored), count pulse width.
  task automatic do_clear(input bit pix_during);
    int n;
    n = 0;
    ctrl[1] = 1'b1;
    step();
    ctrl[1] = 1'b0;
    lz_all(1'b1);
    for (int i = 0; i < 20; i++) begin
      if (!clear_dma_and_fifo) break;
      n++;
      chk("vz_in_clear", 32'({y_vz, u_vz, v_vz}), 0);
      ctrl[1] = (i == 3 || i == 4);
      if (pix_during) begin
        pix_valid = 1'b1;
        pix_sof   = (i == 0);
        pix_data  = {8'hEE, 8'(8'hE0 + i)};
      end
      step();
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    ctrl[1]   = 1'b0;
    chk("clear_len", 32'(n), CLR_N);
    chk("ovf_after_clear", 32'(status_overflow), 0);
    repeat (3) step();
    chk("vz_after_clear", 32'({y_vz, u_vz, v_vz}), 0);
  endtask

  // Every handshake transfer must match the oldest queued byte of that channel.
  always @(negedge clk) begin
    if (rst_n) begin
      if (y_vz && y_lz) begin
        if (yq.size() == 0) chk("y_unexpected", 32'(yq.size()), 1);
        else                chk("y_data", 32'(y_z), 32'(yq.pop_front()));
      end
      if (u_vz && u_lz) begin
        if (uq.size() == 0) chk("u_unexpected", 32'(uq.size()), 1);
        else                chk("u_data", 32'(u_z), 32'(uq.pop_front()));
      end
      if (v_vz && v_lz) begin
        if (vq.size() == 0) chk("v_unexpected", 32'(vq.size()), 1);
        else                chk("v_data", 32'(v_z), 32'(vq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; ctrl = '0;
    lz_all(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vz", 32'({y_vz, u_vz, v_vz}), 0);
    chk("rst_z", 32'({y_z, u_z, v_z}), 0);
    chk("rst_ovf", 32'(status_overflow), 0);
    chk("rst_clear", 32'(clear_dma_and_fifo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Streaming, no backpressure
    ctrl = 4'b0001;
    lz_all(1'b1);
    chk("vz_before_first", 32'(y_vz), 0);
    for (int i = 0; i < 8; i++) begin
      yq.push_back(8'(8'h10 + i));
      if (i % 2 == 0) uq.push_back(8'(8'hA0 + i));
      else            vq.push_back(8'(8'hA0 + i));
      pix(8'(8'h10 + i), 8'(8'hA0 + i), i == 0);
      if (i == 0) chk("first_y_vz", 32'(y_vz), 1);
    end
    repeat (4) step();
    chk_drained("stream_drained");
    chk("stream_ovf", 32'(status_overflow), 0);

    // Backpressure: third pair refused
    lz_all(1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        yq.push_back(8'(8'h20 + i));
        if (i % 2 == 0) uq.push_back(8'(8'hB0 + i));
        else            vq.push_back(8'(8'hB0 + i));
      end
      pix(8'(8'h20 + i), 8'(8'hB0 + i), i == 0);
    end
    chk("bp_ovf", 32'(status_overflow), 1);
    y_lz = 1'b1;
    repeat (6) step();
    chk("bp_y_empty", 32'(y_vz), 0);
    chk("bp_y_q", 32'(yq.size()), 0);
    chk("bp_uv_held", 32'(uq.size() + vq.size()), 4);

    // Stall hold and single-cycle load pulse
    for (int i = 0; i < 5; i++) begin
      chk("stall_u_vz", 32'(u_vz), 1);
      chk("stall_u_z", 32'(u_z), 'hB0);
      step();
    end
    u_lz = 1'b1;
    step();
    u_lz = 1'b0;
    chk("pulse_u_z", 32'(u_z), 'hB2);
    chk("pulse_u_q", 32'(uq.size()), 1);
    lz_all(1'b1);
    repeat (4) step();
    chk_drained("bp_drained");

    // Clear with overflow set and FIFOs partly full
    lz_all(1'b0);
    pix(8'h2A, 8'hBA, 1'b1);
    pix(8'h2B, 8'hBB, 1'b0);
    chk("pre_clear_ovf", 32'(status_overflow), 1);
    chk("pre_clear_vz", 32'({y_vz, u_vz, v_vz}), 3'b111);
    do_clear(1'b1);
    chk_drained("clear_no_emit");

    // Frame restart on an odd-expected pixel
    pix(8'h30, 8'hC0, 1'b1); yq.push_back(8'h30); uq.push_back(8'hC0);
    pix(8'h31, 8'hC1, 1'b1); yq.push_back(8'h31); uq.push_back(8'hC1);
    pix(8'h32, 8'hC2, 1'b0); yq.push_back(8'h32); vq.push_back(8'hC2);
    chk("sof_ovf", 32'(status_overflow), 1);
    repeat (4) step();
    chk_drained("sof_drained");
    do_clear(1'b0);

    // Disable between even and odd pixel
    yq.push_back(8'h40); uq.push_back(8'hD0);
    pix(8'h40, 8'hD0, 1'b1);
    ctrl[0] = 1'b0;
    yq.push_back(8'h41); vq.push_back(8'hD1);
    pix(8'h41, 8'hD1, 1'b0);
    pix(8'h42, 8'hD2, 1'b0);
    pix(8'h43, 8'hD3, 1'b0);
    chk("disable_no_ovf", 32'(status_overflow), 0);
    repeat (4) step();
    chk_drained("disable_drained");
    ctrl[0] = 1'b1;

    // Refused pairs: two fit, three are dropped
    lz_all(1'b0);
    for (int i = 0; i < 10; i++) pix(8'(8'h60 + i), 8'(8'h70 + i), i == 0);
    chk("drop_ovf", 32'(status_overflow), 1);
`ifdef YUV_TX_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), 3);
`endif
    do_clear(1'b0);
`ifdef YUV_TX_DROP_CNT_EN
    chk("drop_count_clr", 32'(drop_count), 0);
`endif

    // Asynchronous reset mid-stream
    lz_all(1'b0);
    pix(8'h50, 8'hE0, 1'b1);
    pix(8'h51, 8'hE1, 1'b0);
    chk("pre_rst_vz", 32'(y_vz), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vz", 32'({y_vz, u_vz, v_vz}), 0);
    chk("async_rst_z", 32'(y_z), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lz_all(1'b1);
    repeat (5) step();
    chk("post_rst_quiet", 32'({y_vz, u_vz, v_vz}), 0);
    yq.push_back(8'h52); uq.push_back(8'hE2);
    pix(8'h52, 8'hE2, 1'b1);
    yq.push_back(8'h53); vq.push_back(8'hE3);
    pix(8'h53, 8'hE3, 1'b0);
    repeat (4) step();
    chk_drained("final_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
